// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, address layout and the
// dimension-ordered (X then Y) route computation for mesh and torus networks.
package noc_pkg;

  localparam int NOC_PORTS  = 5;
  localparam int NOC_X_BITS = 3;
  localparam int NOC_Y_BITS = 2;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_LEFT  = 3'd1,
    PORT_RIGHT = 3'd2,
    PORT_UP    = 3'd3,
    PORT_DOWN  = 3'd4
  } port_e;

  typedef struct packed {
    logic [NOC_X_BITS-1:0] x;
    logic [NOC_Y_BITS-1:0] y;
  } noc_addr_t;

  // torus=1 picks the shorter wrap-around direction per axis (ties go +x/+y);
  // torus=0 is a plain mesh where wrap links never exist.
  function automatic port_e noc_route(input bit torus,
                                      input int dx, input int dy,
                                      input int lx, input int ly,
                                      input int cols, input int rows);
    int    fwd;
    port_e dir;
    fwd = 0;
    dir = PORT_LOCAL;
    if (dx != lx) begin
      if (torus) begin
        fwd = (dx >= lx) ? (dx - lx) : (dx + cols - lx);
        dir = (fwd <= cols - fwd) ? PORT_RIGHT : PORT_LEFT;
      end else begin
        dir = (dx > lx) ? PORT_RIGHT : PORT_LEFT;
      end
    end else if (dy != ly) begin
      if (torus) begin
        fwd = (dy >= ly) ? (dy - ly) : (dy + rows - ly);
        dir = (fwd <= rows - fwd) ? PORT_UP : PORT_DOWN;
      end else begin
        dir = (dy > ly) ? PORT_UP : PORT_DOWN;
      end
    end
    return dir;
  endfunction

endpackage

// File: rtl/noc_router_sync_if.sv
// Five-port valid/ready packet bundle between a router and its neighbours.
interface noc_router_sync_if
  import noc_pkg::*;
#(
  parameter int WIDTH_PACKAGE = 33
);
  logic [NOC_PORTS-1:0]                    in_valid;
  logic [NOC_PORTS-1:0]                    in_ready;
  logic [NOC_PORTS-1:0][WIDTH_PACKAGE-1:0] in_data;
  logic [NOC_PORTS-1:0]                    out_valid;
  logic [NOC_PORTS-1:0]                    out_ready;
  logic [NOC_PORTS-1:0][WIDTH_PACKAGE-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/noc_fifo.sv
// Per-port input FIFO; head entry is visible combinationally so a packet
// written at one edge can be granted at the next.
module noc_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is not reset: emptiness is decided by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[PW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_q[PW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

endmodule

// File: rtl/noc_router_sync.sv
// Five-port XY router: input FIFOs, per-output round-robin arbiter and one
// output register stage. Define NOC_TORUS_EN to route over wrap-around links.
module noc_router_sync
  import noc_pkg::*;
#(
  parameter int                         WIDTH_PACKAGE = 33,
  parameter int                         X_BITS        = 3,
  parameter int                         Y_BITS        = 2,
  parameter int                         COLS          = 5,
  parameter int                         ROWS          = 3,
  parameter logic [X_BITS+Y_BITS-1:0]   ROUTER_LOC    = 5'b000_00,
  parameter int                         FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  noc_router_sync_if.slave   bus
);
  localparam int AW = X_BITS + Y_BITS;
`ifdef NOC_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif

  logic [WIDTH_PACKAGE-1:0] head [NOC_PORTS];
  logic [NOC_PORTS-1:0]     fifo_empty;
  logic [NOC_PORTS-1:0]     fifo_full;
  logic [NOC_PORTS-1:0]     fifo_pop;
  port_e                    dir [NOC_PORTS];
  logic [NOC_PORTS-1:0]     gnt_mat [NOC_PORTS];

  for (genvar gi = 0; gi < NOC_PORTS; gi++) begin : g_in
    logic pop;

    noc_fifo #(
      .WIDTH (WIDTH_PACKAGE),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (bus.in_valid[gi] & bus.in_ready[gi]),
      .data_i  (bus.in_data[gi]),
      .pop_i   (fifo_pop[gi]),
      .data_o  (head[gi]),
      .empty_o (fifo_empty[gi]),
      .full_o  (fifo_full[gi])
    );

    // Held low during reset so nothing is offered as accepted mid-reset.
    assign bus.in_ready[gi] = ~fifo_full[gi] & rst_n;

    assign dir[gi] = noc_route(TORUS,
                               int'(head[gi][WIDTH_PACKAGE-1 -: X_BITS]),
                               int'(head[gi][WIDTH_PACKAGE-X_BITS-1 -: Y_BITS]),
                               int'(ROUTER_LOC[AW-1 -: X_BITS]),
                               int'(ROUTER_LOC[Y_BITS-1:0]),
                               COLS, ROWS);

    // Each head routes to exactly one output, so at most one grant arrives here.
    always_comb begin
      pop = 1'b0;
      for (int o = 0; o < NOC_PORTS; o++) pop = pop | gnt_mat[o][gi];
    end
    assign fifo_pop[gi] = pop;
  end

  for (genvar go = 0; go < NOC_PORTS; go++) begin : g_out
    logic [NOC_PORTS-1:0]     req;
    logic [NOC_PORTS-1:0]     gnt_vec;
    logic [2:0]               gnt_idx;
    logic                     gnt_any;
    logic                     can_load;
    logic [3:0]               sum;
    logic [2:0]               ptr_q, ptr_d;
    logic                     vld_q, vld_d;
    logic [WIDTH_PACKAGE-1:0] data_q, data_d;

    for (genvar gr = 0; gr < NOC_PORTS; gr++) begin : g_req
      assign req[gr] = ~fifo_empty[gr] & (dir[gr] == port_e'(go));
    end

    always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_vec  = '0;
      sum      = '0;
      can_load = ~vld_q | bus.out_ready[go];
      // Scan starting at the pointer; the first requester found wins.
      for (int k = 0; k < NOC_PORTS; k++) begin
        sum = {1'b0, ptr_q} + 4'(k);
        if (sum >= 4'(NOC_PORTS)) sum = sum - 4'(NOC_PORTS);
        if (can_load && !gnt_any && req[sum[2:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = sum[2:0];
        end
      end
      if (gnt_any) gnt_vec[gnt_idx] = 1'b1;

      ptr_d  = ptr_q;
      vld_d  = vld_q;
      data_d = data_q;
      if (gnt_any) begin
        ptr_d  = (gnt_idx == 3'(NOC_PORTS - 1)) ? 3'd0 : gnt_idx + 3'd1;
        vld_d  = 1'b1;
        data_d = head[gnt_idx];
      end else if (bus.out_ready[go]) begin
        vld_d  = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr_q  <= '0;
        vld_q  <= 1'b0;
        data_q <= '0;
      end else begin
        ptr_q  <= ptr_d;
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    assign gnt_mat[go]       = gnt_vec;
    assign bus.out_valid[go] = vld_q;
    assign bus.out_data[go]  = data_q;
  end

endmodule

// File: tb/tb_noc_router_sync.sv
// Router bench at location {x=1,y=1}: routing table, arbitration, backpressure
// and reset-discard sequences, all checked against a per-output scoreboard.
module tb_noc_router_sync;
  import noc_pkg::*;

  localparam int         W   = 33;
  localparam logic [4:0] LOC = 5'b001_01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_router_sync_if #(.WIDTH_PACKAGE(W)) bus ();

  noc_router_sync #(
    .WIDTH_PACKAGE (W),
    .X_BITS        (3),
    .Y_BITS        (2),
    .COLS          (5),
    .ROWS          (3),
    .ROUTER_LOC    (LOC),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q [5][$];
  logic [W-1:0] mon_e;

  typedef struct {
    int         in_p;
    logic [4:0] dest;
    int         exp_o;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] pkt(input logic [4:0] dest, input int tag);
    return {dest, 28'(tag)};
  endfunction

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
           exp_q[3].size() + exp_q[4].size();
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input int p, input logic [W-1:0] d, input int o, input bit sb);
    int t = 0;
    bus.in_valid[p] = 1'b1;
    bus.in_data[p]  = d;
    @(negedge clk);
    while (!bus.in_ready[p] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready[p]) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout port %0d: got in_ready 0 required 1", p);
    end else begin
      if (sb) exp_q[o].push_back(d);
      $display("send in %0d data %h expect out %0d", p, d, o);
    end
    @(posedge clk);
    #1;
    bus.in_valid[p] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (pending() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({name, "_drained"}, 64'(pending()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // A transfer is committed at the posedge that follows this sample point.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int o = 0; o < 5; o++) begin
        if (bus.out_valid[o] && bus.out_ready[o]) begin
          if (exp_q[o].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out port %0d: got %h required nothing", o, bus.out_data[o]);
          end else begin
            mon_e = exp_q[o].pop_front();
            $display("recv out %0d data %h", o, bus.out_data[o]);
            chk($sformatf("out%0d_data", o), 64'(bus.out_data[o]), 64'(mon_e));
          end
        end
      end
    end
  end

  initial begin
    int acc;
    int tag;
    logic [W-1:0] d;

    vecs[0] = '{PORT_LOCAL, 5'b011_01, PORT_RIGHT};
    vecs[1] = '{PORT_LOCAL, 5'b001_01, PORT_LOCAL};
    vecs[2] = '{PORT_LOCAL, 5'b000_01, PORT_LEFT};
`ifdef NOC_TORUS_EN
    vecs[3] = '{PORT_LOCAL, 5'b100_01, PORT_LEFT};
`else
    vecs[3] = '{PORT_LOCAL, 5'b100_01, PORT_RIGHT};
`endif
    vecs[4] = '{PORT_LOCAL, 5'b001_10, PORT_UP};
    vecs[5] = '{PORT_LOCAL, 5'b001_00, PORT_DOWN};
    vecs[6] = '{PORT_LEFT,  5'b010_00, PORT_RIGHT};
    vecs[7] = '{PORT_UP,    5'b001_01, PORT_LOCAL};
    vecs[8] = '{PORT_DOWN,  5'b000_10, PORT_LEFT};
    vecs[9] = '{PORT_RIGHT, 5'b001_10, PORT_UP};

    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 5'b11111;

    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    for (int o = 0; o < 5; o++) chk($sformatf("rst_out_data%0d", o), 64'(bus.out_data[o]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'h1f);

    // Round-robin between LEFT and UP competing for LOCAL, pointers fresh from reset.
    for (int i = 0; i < 3; i++) begin
      exp_q[PORT_LOCAL].push_back(pkt(LOC, 16'h100 + i));
      exp_q[PORT_LOCAL].push_back(pkt(LOC, 16'h300 + i));
    end
    fork
      for (int i = 0; i < 3; i++) send(PORT_LEFT, pkt(LOC, 16'h100 + i), PORT_LOCAL, 1'b0);
      for (int i = 0; i < 3; i++) send(PORT_UP,   pkt(LOC, 16'h300 + i), PORT_LOCAL, 1'b0);
    join
    wait_drain("rr");

    // Minimum latency: accepted at edge N, visible after edge N+1.
    d = pkt(5'b011_01, 16'h0abc);
    bus.in_valid[PORT_LOCAL] = 1'b1;
    bus.in_data[PORT_LOCAL]  = d;
    @(negedge clk);
    chk("lat_in_ready", 64'(bus.in_ready[PORT_LOCAL]), 64'd1);
    exp_q[PORT_RIGHT].push_back(d);
    @(posedge clk);
    #1;
    bus.in_valid[PORT_LOCAL] = 1'b0;
    @(negedge clk);
    chk("lat_n_valid", 64'(bus.out_valid[PORT_RIGHT]), 64'd0);
    @(negedge clk);
    chk("lat_n1_valid", 64'(bus.out_valid[PORT_RIGHT]), 64'd1);
    chk("lat_n1_data", 64'(bus.out_data[PORT_RIGHT]), 64'(d));
    @(posedge clk);
    #1;
    wait_drain("lat");

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].in_p, pkt(vecs[i].dest, 16'h500 + i), vecs[i].exp_o, 1'b1);
      wait_drain($sformatf("vec%0d", i));
    end

    // Backpressure: FIFO depth 4 plus the output register hold five packets.
    bus.out_ready[PORT_RIGHT] = 1'b0;
    acc = 0;
    tag = 16'h700;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid[PORT_LOCAL] = 1'b1;
      bus.in_data[PORT_LOCAL]  = pkt(5'b011_01, tag);
      @(negedge clk);
      if (bus.in_ready[PORT_LOCAL]) begin
        exp_q[PORT_RIGHT].push_back(pkt(5'b011_01, tag));
        $display("send in 0 data %h expect out 2", pkt(5'b011_01, tag));
        acc++;
        tag++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid[PORT_LOCAL] = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_in_ready", 64'(bus.in_ready[PORT_LOCAL]), 64'd0);
    bus.out_ready[PORT_RIGHT] = 1'b1;
    wait_drain("bp");

    // Reset in the middle of a stream discards everything in flight.
    for (int c = 0; c < 4; c++) begin
      bus.in_valid[PORT_LOCAL] = 1'b1;
      bus.in_data[PORT_LOCAL]  = pkt(5'b011_01, 16'h900 + c);
      @(negedge clk);
      if (bus.in_ready[PORT_LOCAL]) exp_q[PORT_RIGHT].push_back(pkt(5'b011_01, 16'h900 + c));
      if (c < 3) begin
        @(posedge clk);
        #1;
      end
    end
    chk("mid_valid_before", 64'(bus.out_valid[PORT_RIGHT]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_out_data", 64'(bus.out_data[PORT_RIGHT]), 64'd0);
    bus.in_valid = '0;
    for (int o = 0; o < 5; o++) exp_q[o].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_post_in_ready", 64'(bus.in_ready), 64'h1f);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_stale", 64'(bus.out_valid), 64'd0);

    chk("final_scoreboard_empty", 64'(pending()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule

// File: doc/noc_router_sync.md
NOC_ROUTER_SYNC -- requirements
Module: noc_router_sync

Interface
REQ-001 Parameter WIDTH_PACKAGE, default 33: packet width in bits.
REQ-002 Parameter X_BITS, default 3: destination-X field width.
REQ-003 Parameter Y_BITS, default 2: destination-Y field width.
REQ-004 Parameter COLS, default 5: number of columns in the network (X range 0..COLS-1).
REQ-005 Parameter ROWS, default 3: number of rows in the network (Y range 0..ROWS-1).
REQ-006 Parameter ROUTER_LOC, default 5'b000_00: this router's address {x,y}, X_BITS+Y_BITS wide.
REQ-007 Parameter FIFO_DEPTH, default 4: input FIFO entries per port; power of 2, minimum 2.
REQ-008 clk  input  1  single clock; all state on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 in_valid  input  5  per-port packet offered; port index LOCAL=0, LEFT=1, RIGHT=2, UP=3, DOWN=4.
REQ-011 in_ready  output  5  per-port input FIFO can accept.
REQ-012 in_data  input  5xWIDTH_PACKAGE  per-port packet; destination = top X_BITS+Y_BITS bits, {x,y}.
REQ-013 out_valid  output  5  per-port output register holds a packet.
REQ-014 out_ready  input  5  per-port downstream accepts.
REQ-015 out_data  output  5xWIDTH_PACKAGE  per-port packet, passed through unmodified.

Function
REQ-016 Transfer on any port: valid&ready at a rising edge; no other transfer condition.
REQ-017 in_ready[p] SHALL be 1 exactly when FIFO p is not full; a pop in the same cycle does not raise it.
REQ-018 Routing on FIFO head, dimension order X then Y: dest==ROUTER_LOC -> LOCAL; dest.x != loc.x -> RIGHT (+x) or LEFT (-x); otherwise UP (+y) or DOWN (-y).
REQ-019 Direction choice: see Configuration.
REQ-020 Each output has one register stage and a round-robin arbiter over the inputs whose head routes to it.
REQ-021 Grant is allowed when the output register is empty or drains in the same cycle (out_valid&out_ready).
REQ-022 On grant: pop the winning FIFO and load the output register at the same edge.
REQ-023 Round-robin pointer moves to one past the granted input; it does not move when there is no grant.
REQ-024 An input may receive at most one grant per cycle. Distinct outputs granting distinct inputs SHALL proceed in parallel.
REQ-025 Minimum latency: accept at edge N -> out_valid high from edge N+1 (FIFO write N, grant/load N+1, visible cycle N+2).
REQ-026 While out_valid&!out_ready, out_data SHALL remain stable.
REQ-027 A packet entering on LOCAL and addressed to ROUTER_LOC SHALL loop back on LOCAL.
REQ-028 Packets are never dropped, duplicated or reordered between one input/output pair.

Reset
REQ-029 rst_n low SHALL asynchronously empty all FIFOs and clear out_valid=0, out_data=0 and all arbiter pointers=0.
REQ-030 in_ready SHALL be 0 while rst_n is low, and all-ones in the first cycle after release.
REQ-031 Assertion mid-transfer SHALL discard all in-flight packets; no partial state survives.

Configuration
REQ-032 Macro NOC_TORUS_EN defined: wrap-around links are used; per axis take the shorter modular distance; a tie goes to RIGHT/UP.
REQ-033 Macro NOC_TORUS_EN undefined: plain mesh; RIGHT/UP when dest coordinate > loc coordinate, else LEFT/DOWN; wrap links are never used.

Structure
REQ-034 Package noc_pkg SHALL hold the port index constants, address field widths, the address typedef and the route-compute function (torus and mesh variants).
REQ-035 The per-port input FIFO SHALL be the sub-module noc_fifo (parameters WIDTH, DEPTH) and SHALL be instantiated 5 times.

Verification
REQ-036 Setup ROUTER_LOC=5'b001_01. LOCAL injects dest 5'b011_01 at edge N -> RIGHT out_valid at edge N+1, data identical.
REQ-037 Dest 5'b100_01 on LOCAL -> LEFT with NOC_TORUS_EN; RIGHT without it.
REQ-038 LEFT and UP each send 3 packets to dest 5'b001_01 in the same cycle, out_ready[LOCAL]=1 -> LOCAL outputs alternate LEFT, UP, LEFT, UP, LEFT, UP.
REQ-039 out_ready[RIGHT]=0, FIFO_DEPTH=4, LOCAL streams to dest 5'b011_01 -> 5 packets accepted, then in_ready[LOCAL]=0. Raising out_ready drains all 5 in order.
REQ-040 Pull rst_n low mid-stream -> out_valid=0 immediately. After release: in_ready=5'b11111, no stale packet emerges.
